oai211_pattern_driver: RTL



---
 rtl/oai211_pattern_driver_if.sv | 27 ++
 rtl/oai211_pattern_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/oai211_pattern_driver_if.sv
// Signal bundle between the OAI211 pattern driver (master) and the cell/controller side (slave).
interface oai211_pattern_driver_if #(
  parameter int unsigned ERR_W = 8
);
  logic             START;
  logic             ZN_IN;
  logic             A1;
  logic             A2;
  logic             B;
  logic             C;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [3:0]       FIRST_FAIL;
  logic [15:0]      SIG;

  modport master (
    input  START, ZN_IN,
    output A1, A2, B, C, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, SIG
  );

  modport slave (
    output START, ZN_IN,
    input  A1, A2, B, C, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, SIG
  );
endinterface

// File: rtl/oai211_pattern_driver.sv
// OAI211 pattern driver: walks all 16 {A1,A2,B,C} vectors, samples ZN after a settle
// time, compares against ~((A1|A2)&B&C) and reports pass/fail, error count and first
// failing vector. Optional response MISR on SIG when OAI211_PATTERN_DRIVER_SIG_EN is defined.
module oai211_pattern_driver #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LOOPS      = 1,
  parameter int unsigned ERR_W      = 8
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  VDD,
  inout  wire  VSS,
  oai211_pattern_driver_if.master io
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 2);
  localparam int unsigned LOOP_W = $clog2(LOOPS + 1);

  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [SET_W-1:0]  SET_LOAD    = SET_W'(SETTLE_CYC);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST    = 4'hF;
  localparam bit                ZERO_SETTLE = (SETTLE_CYC == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [VEC_W-1:0]  ff_q, ff_d;
  logic              zn_exp;
  logic              mism;

  // Supplies carry no logic; they are only observed so they are not flagged as dangling.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      loop_q  <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // Next-state, drive vector and result bookkeeping
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    set_d   = set_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;

    zn_exp = ~((vec_q[3] | vec_q[2]) & vec_q[1] & vec_q[0]);
    mism   = (io.ZN_IN != zn_exp);

    case (state_q)
      S_IDLE: begin
        if (io.START) begin
          vec_d   = '0;
          loop_d  = '0;
          set_d   = SET_LOAD;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = 4'hF;
          state_d = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (set_q <= SET_W'(1)) begin
          state_d = S_SAMPLE;
        end else begin
          set_d = set_q - SET_W'(1);
        end
      end

      S_SAMPLE: begin
        if (mism) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          // Saturation never returns to zero, so zero means no earlier mismatch.
          if (err_q == '0) begin
            ff_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST && loop_q == LOOP_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + VEC_W'(1);
          if (vec_q == VEC_LAST) begin
            loop_d = loop_q + LOOP_W'(1);
          end
          set_d   = SET_LOAD;
          state_d = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        vec_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef OAI211_PATTERN_DRIVER_SIG_EN
  localparam logic [15:0] MISR_POLY = 16'h1021;

  logic [15:0] sig_q;

  // Response MISR (x^16+x^12+x^5+1), ZN sample folded into bit 0 on every sample edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      sig_q <= '0;
    end else if (state_q == S_IDLE && io.START) begin
      sig_q <= '0;
    end else if (state_q == S_SAMPLE) begin
      sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {15'h0000, io.ZN_IN};
    end
  end

  assign io.SIG = sig_q;
`else
  assign io.SIG = 16'h0000;
`endif

  assign io.A1         = vec_q[3];
  assign io.A2         = vec_q[2];
  assign io.B          = vec_q[1];
  assign io.C          = vec_q[0];
  assign io.BUSY       = busy_q;
  assign io.DONE       = done_q;
  assign io.PASS       = pass_q;
  assign io.ERR_CNT    = err_q;
  assign io.FIRST_FAIL = ff_q;

endmodule
